button_press_decoder: RTL
=========================

// Module: button_press_decoder
// PURPOSE
//  Input-side counterpart of the LED output path. Takes one raw push-button pin
//  on the Vaman board, synchronises it to the fabric clock and debounces it.
//  It then decodes each press as short or long and emits single-cycle event
//  pulses that downstream logic (LED mode/blink-rate selection) consumes.
//  Internal clock only; no external handshake.
// PARAMETERS
//  ACTIVE_LOW      1         1: pin reads 0 when pressed; 0: pin reads 1 when pressed
//  SYNC_STAGES     2         flip-flops in input synchroniser, >=2
//  DEBOUNCE_CYCLES 200000    consecutive stable synced samples to accept a change, >=1
//  LONG_CYCLES     20000000  held cycles after press_pulse that classify a long press, >DEBOUNCE_CYCLES
//  CNT_W           25        counter width, 2**CNT_W > LONG_CYCLES
// PORTS
//  clk            in   1  fabric clock (Sys_Clk0)
//  rst_n          in   1  asynchronous, active-low reset
//  btn_raw        in   1  raw, unsynchronised button pin
//  btn_level      out  1  debounced level, 1 = pressed
//  press_pulse    out  1  1-cycle pulse on debounced press
//  release_pulse  out  1  1-cycle pulse on debounced release
//  short_pulse    out  1  1-cycle pulse on release of a press held <LONG_CYCLES
//  long_pulse     out  1  1-cycle pulse once a press has been held LONG_CYCLES
//  long_held      out  1  high from long_pulse until release_pulse (inclusive)
// BEHAVIOUR
//  - Reset: all outputs 0, sync chain loaded with the released level, counters 0, FSM IDLE.
//  - Normalise: pressed = btn_raw ^ ACTIVE_LOW, then pass through SYNC_STAGES flops.
//  - Debounce: counter increments while synced sample != btn_level, and clears on any agreeing sample.
//    When the count reaches DEBOUNCE_CYCLES, btn_level flips and the counter clears.
//    Glitches shorter than DEBOUNCE_CYCLES never reach btn_level.
//  - Latency: btn_level changes SYNC_STAGES+DEBOUNCE_CYCLES cycles after the first
//    clock edge that samples the new pin value (pin then held stable).
//  - press_pulse/release_pulse are registered and assert in the same cycle btn_level rises/falls.
//  - FSM states: IDLE, PRESSED, LONG.
//    IDLE->PRESSED on debounced press; duration counter cleared.
//    PRESSED: duration counter increments each cycle; at LONG_CYCLES -> LONG and long_pulse.
//    PRESSED->IDLE on debounced release, with short_pulse in the same cycle as release_pulse.
//    LONG->IDLE on debounced release, with release_pulse only (no short_pulse).
//  - long_pulse fires exactly LONG_CYCLES cycles after press_pulse, at most once per press.
//  - Duration counter saturates; it never wraps while held.
//  - Simultaneous: if release is accepted in the cycle the duration would reach LONG_CYCLES,
//    release wins: short_pulse, no long_pulse.
//  - At most one of press_pulse/release_pulse per cycle; pulses never repeat without new edges.
//  - Button held through reset deassertion: treated as a fresh press, with press_pulse
//    after SYNC_STAGES+DEBOUNCE_CYCLES cycles.
//  - Reset mid-press: outputs drop to 0 asynchronously; no release/short pulse emitted.
// STRUCTURE
//  - Shared package: FSM state enum {IDLE, PRESSED, LONG}, 2-bit encoding.
//  - Sub-module debounce_filter: synchroniser + debounce counter, outputs the
//    debounced level and rise/fall strobes.
//  - Top level holds the classification FSM, the duration counter and the output registers.
// TESTING  (bench parameters DEBOUNCE_CYCLES=4, LONG_CYCLES=20, SYNC_STAGES=2, ACTIVE_LOW=1)
//  - Reset: hold rst_n=0 with btn_raw=1 -> all outputs 0; release reset -> outputs stay 0 for 100 cycles.
//  - Bounce: pulse btn_raw low for 3 cycles, 3 times with 1-cycle gaps -> no output ever changes.
//  - Short press: btn_raw=0 for 12 cycles then 1 -> press_pulse 6 cycles after the falling edge;
//    release_pulse + short_pulse 6 cycles after the rising edge; no long_pulse.
//  - Long press: btn_raw=0 for 40 cycles -> long_pulse exactly 20 cycles after press_pulse;
//    long_held 1 until release_pulse; no short_pulse.
//  - Boundary: release timed so the debounced release lands exactly 20 cycles after press_pulse
//    -> short_pulse, no long_pulse.
//  - Reset mid-press: assert rst_n=0 while long_held=1 -> all outputs 0 immediately;
//    with btn held low after reset -> new press_pulse 6 cycles later.

Source files
------------

// File: rtl/button_press_decoder_pkg.sv
// Shared definitions for the push-button decoder.
//   state_e : classification FSM state (IDLE, PRESSED, LONG), 2-bit encoding.
package button_press_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_e;

endpackage

// File: rtl/button_press_decoder_debounce_filter.sv
// Synchroniser and debounce filter for one raw push-button pin.
// The pin is first normalised so that 1 means pressed, then it passes through
// a SYNC_STAGES flip-flop chain. A change is accepted only after it has been
// seen on enough consecutive synced samples.
// Ports:
//   clk_i      : fabric clock
//   rst_ni     : asynchronous active-low reset
//   btn_raw_i  : raw, unsynchronised button pin
//   level_o    : debounced level, 1 = pressed (registered)
//   rise_o     : level_o rises at the next clock edge (combinational strobe)
//   fall_o     : level_o falls at the next clock edge (combinational strobe)
module debounce_filter #(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int CNT_W           = 25
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] DEB_TERM = CNT_W'(DEBOUNCE_CYCLES);

  logic                   pressed;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   accept;

  assign pressed = btn_raw_i ^ ACTIVE_LOW;
  assign synced  = sync_q[SYNC_STAGES-1];

  // The flip is taken on the edge after the count has reached DEB_TERM, so the
  // total latency from the first sampling edge is SYNC_STAGES + DEBOUNCE_CYCLES.
  assign accept = (synced != level_q) && (cnt_q >= DEB_TERM);

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (synced == level_q) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d   = '0;
      level_d = ~level_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // Released level after normalisation is 0.
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pressed};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = accept & ~level_q;
  assign fall_o  = accept &  level_q;

endmodule

// File: rtl/button_press_decoder.sv
// Push-button decoder: debounces one raw button pin and classifies each press
// as short or long, producing single-cycle event pulses for downstream logic.
// Ports:
//   clk           : fabric clock
//   rst_n         : asynchronous active-low reset
//   btn_raw       : raw, unsynchronised button pin
//   btn_level     : debounced level, 1 = pressed
//   press_pulse   : 1-cycle pulse on debounced press
//   release_pulse : 1-cycle pulse on debounced release
//   short_pulse   : 1-cycle pulse on release of a press held < LONG_CYCLES
//   long_pulse    : 1-cycle pulse once a press has been held LONG_CYCLES
//   long_held     : high from long_pulse until release_pulse (inclusive)
module button_press_decoder
  import button_press_decoder_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int LONG_CYCLES     = 20000000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic long_held
);

  // Duration counter value seen on the edge that is LONG_CYCLES after press_pulse.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DUR_MAX   = '1;

  logic       rise, fall;
  state_e     state_q;
  logic [CNT_W-1:0] dur_q;
  logic       press_q, release_q, short_q, long_q, long_held_q;

  debounce_filter #(
    .ACTIVE_LOW      (ACTIVE_LOW),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .btn_raw_i (btn_raw),
    .level_o   (btn_level),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dur_q       <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      long_held_q <= 1'b0;
    end else begin
      // rise/fall announce the level change on this edge, so the pulses
      // register in the same cycle btn_level changes.
      press_q   <= rise;
      release_q <= fall;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          // long_held stays up through the release cycle and drops here.
          long_held_q <= 1'b0;
          if (rise) begin
            state_q <= PRESSED;
            dur_q   <= '0;
          end
        end
        PRESSED: begin
          // Release is checked first so it wins over a coincident long threshold.
          if (fall) begin
            state_q <= IDLE;
            short_q <= 1'b1;
          end else if (dur_q == LONG_LAST) begin
            state_q     <= LONG;
            long_q      <= 1'b1;
            long_held_q <= 1'b1;
          end else if (dur_q != DUR_MAX) begin
            dur_q <= dur_q + CNT_W'(1);
          end
        end
        LONG: begin
          if (dur_q != DUR_MAX) begin
            dur_q <= dur_q + CNT_W'(1);
          end
          if (fall) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_pulse   = short_q;
  assign long_pulse    = long_q;
  assign long_held     = long_held_q;

endmodule
